// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud tick divisor calculation.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned OVS     = 16;
  localparam int unsigned OVS_MID = OVS / 2 - 1;

  // Truncating divisor: clk cycles per oversampling tick.
  function automatic int unsigned baud_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / (OVS * baud_rate);
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Free-running 16x oversampling tick generator; shared with the transmitter.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, mid-bit sampling, with framing
// error flag and break (held-low line) suppression.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID       = SW'(OVS_MID);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic            s_tick;
  logic            sync1_q, rx_s_q;
  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  uart_baud_tick #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (s_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            dout_d  = b_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s_q;
            // A low stop bit may be the start of a break; wait for release.
            state_d = rx_s_q ? IDLE : BREAK;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, received
// frames compared against an expected-frame queue built from the sent bytes.
module tb_uart_rx;

  localparam int unsigned CF      = 1_600_000;
  localparam int unsigned BR      = 10_000;
  localparam int unsigned DIV     = CF / (16 * BR);
  localparam int unsigned BIT_CLK = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       rx_busy;

  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  int unsigned got_cyc[$];
  logic        prev_done = 1'b0;

  uart_rx #(
    .DBIT      (8),
    .SB_TICK   (16),
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Capture every done pulse with the data/flag it presents.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      check("done_single", {31'd0, prev_done}, 32'd0);
      got_q.push_back({frame_err, rx_dout});
      got_cyc.push_back(cyc);
    end
    prev_done = rx_done_tick;
  end

  task automatic drive_bit(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Line-level transmitter plus the reference expectation for the frame.
  task automatic send(input logic [7:0] d, input logic stop, input int unsigned bitc);
    drive_bit(1'b0, bitc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bitc);
    drive_bit(stop, bitc);
    exp_q.push_back({~stop, d});
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_frame"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    int unsigned t0;
    int unsigned dt;
    logic [7:0]  last;
    logic [7:0]  d;

    repeat (4) @(negedge clk);
    check("reset_dout", {24'd0, rx_dout}, 32'd0);
    check("reset_done", {31'd0, rx_done_tick}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    reset_n = 1'b1;
    drive_bit(1'b1, BIT_CLK);

    // Single frame, with pulse timing relative to the stop-bit centre.
    t0 = cyc;
    send(8'hA5, 1'b1, BIT_CLK);
    drive_bit(1'b1, 2 * BIT_CLK);
    if (got_cyc.size() > 0) begin
      dt = got_cyc[0] - t0;
      check("a5_pulse_window", {31'd0, (dt >= (19 * BIT_CLK) / 2) && (dt <= (19 * BIT_CLK) / 2 + 8 * DIV)}, 32'd1);
    end else begin
      check("a5_pulse_seen", got_cyc.size(), 32'd1);
    end
    compare_frames("a5");

    // Back-to-back frames, no idle gap.
    send(8'h00, 1'b1, BIT_CLK);
    send(8'hFF, 1'b1, BIT_CLK);
    send(8'h3C, 1'b1, BIT_CLK);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("b2b");

    // Short low glitch must be rejected as a false start.
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("glitch");
    check("glitch_dout", {24'd0, rx_dout}, 32'h3C);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);

    // Framing error followed by a held-low break.
    send(8'h55, 1'b0, BIT_CLK);
    drive_bit(1'b0, 3 * BIT_CLK);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    check("break_ferr", {31'd0, frame_err}, 32'd1);
    drive_bit(1'b1, BIT_CLK);
    check("break_release", {31'd0, rx_busy}, 32'd0);
    compare_frames("break");
    send(8'h12, 1'b1, BIT_CLK);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("after_break");
    check("after_break_ferr", {31'd0, frame_err}, 32'd0);

    // Asynchronous reset partway through the data bits of 0x81.
    d = 8'h81;
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLK);
    drive_bit(d[4], BIT_CLK / 2);
    #2;
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    check("areset_dout", {24'd0, rx_dout}, 32'd0);
    check("areset_ferr", {31'd0, frame_err}, 32'd0);
    check("areset_busy", {31'd0, rx_busy}, 32'd0);
    check("areset_done", {31'd0, rx_done_tick}, 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("aborted");
    send(8'h81, 1'b1, BIT_CLK);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("post_reset");

    // Baud mismatch, 3% slow and 3% fast.
    send(8'hC3, 1'b1, (BIT_CLK * 103) / 100);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("slow3");
    send(8'hC3, 1'b1, (BIT_CLK * 97) / 100);
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("fast3");

    // Random bytes with random idle gaps.
    last = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      last = 8'($urandom);
      send(last, 1'b1, BIT_CLK);
      drive_bit(1'b1, $urandom_range(1, 300));
    end
    drive_bit(1'b1, 2 * BIT_CLK);
    compare_frames("random");
    check("random_hold_dout", {24'd0, rx_dout}, {24'd0, last});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
